// File: rtl/sc_pkg.sv
// Shared types and helpers for stochastic bitstream decoders.
// Holds the FSM state enum, default window limit, k clamp and result conversion.
package sc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int DEF_MAX_LOG2 = 8;

    // Working width for result conversion; wide enough for any MAX_LOG2 <= 14.
    localparam int FN_W = 16;

    function automatic logic [3:0] clamp_k(
        input logic [3:0] k,
        input logic [3:0] kmax
    );
        return (k > kmax) ? kmax : k;
    endfunction

    // Unipolar: ones as-is. Bipolar: 2*ones - 2^k in two's complement.
    function automatic logic [FN_W-1:0] to_result(
        input logic [FN_W-1:0] ones,
        input logic [3:0]      k,
        input logic            bip
    );
        logic [FN_W-1:0] n;
        n = FN_W'(1) << k;
        return bip ? ((ones << 1) - n) : ones;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Window counter: counts qualified bits and ones over a 2^k window.
// Ports: clk, rst_n, clear, vld, sn_bit, k in; last, final_ones out.
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int MAX_LOG2 = DEF_MAX_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                vld,
    input  logic                sn_bit,
    input  logic [3:0]          k,
    output logic                last,
    output logic [MAX_LOG2:0]   final_ones
);

    logic [MAX_LOG2-1:0] bit_cnt;
    logic [MAX_LOG2:0]   ones;
    logic [MAX_LOG2:0]   nm1;

    always_comb begin
        nm1        = ((MAX_LOG2+1)'(1) << k) - (MAX_LOG2+1)'(1);
        last       = vld && ({1'b0, bit_cnt} == nm1);
        final_ones = ones + (MAX_LOG2+1)'(sn_bit);
    end

    // A completed window clears the counters so a continuous run has no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            ones    <= '0;
        end else if (clear || last) begin
            bit_cnt <= '0;
            ones    <= '0;
        end else if (vld) begin
            bit_cnt <= bit_cnt + MAX_LOG2'(1);
            ones    <= final_ones;
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^k valid bits, emits
// unipolar/bipolar result on a valid/ready port with sticky overrun flag.
// Ports: clk, rst_n, sn_bit, sn_valid, win_log2, bipolar, start, continuous,
// abort, result_ready in; busy, result, result_valid, overrun out.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int MAX_LOG2 = DEF_MAX_LOG2,
    parameter int OUT_W    = MAX_LOG2 + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sn_bit,
    input  logic             sn_valid,
    input  logic [3:0]       win_log2,
    input  logic             bipolar,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    output logic             busy,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun
);

    state_t            state;
    state_t            state_n;
    logic              go;
    logic              cnt_vld;
    logic              last;
    logic [MAX_LOG2:0] final_ones;
    logic [3:0]        k_q;
    logic              bip_q;

    sc_window_counter #(
        .MAX_LOG2(MAX_LOG2)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (go),
        .vld       (cnt_vld),
        .sn_bit    (sn_bit),
        .k         (k_q),
        .last      (last),
        .final_ones(final_ones)
    );

    // Abort masks counting, so abort on the last bit yields no result.
    always_comb begin
        state_n = state;
        go      = 1'b0;
        cnt_vld = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    go      = 1'b1;
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                cnt_vld = sn_valid && !abort;
                if (abort) begin
                    state_n = IDLE;
                end else if (last && !continuous) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k_q   <= '0;
            bip_q <= 1'b0;
        end else begin
            state <= state_n;
            if (go) begin
                k_q   <= clamp_k(win_log2, 4'(MAX_LOG2));
                bip_q <= bipolar;
            end
        end
    end

    // A new result takes precedence over acceptance on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (last) begin
                result       <= OUT_W'(to_result(FN_W'(final_ones), k_q, bip_q));
                result_valid <= 1'b1;
                if (result_valid && !result_ready) begin
                    overrun <= 1'b1;
                end
            end else if (result_ready) begin
                result_valid <= 1'b0;
            end
            if (go) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state == ACCUM);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Scoreboard testbench for sc_stream_decoder.
// Directed windows push expected results; a negedge monitor checks transfers.
module tb_sc_stream_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sn_bit;
    logic       sn_valid;
    logic [3:0] win_log2;
    logic       bipolar;
    logic       start;
    logic       continuous;
    logic       abort;
    logic       busy;
    logic [9:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    sc_stream_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sn_bit      (sn_bit),
        .sn_valid    (sn_valid),
        .win_log2    (win_log2),
        .bipolar     (bipolar),
        .start       (start),
        .continuous  (continuous),
        .abort       (abort),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Each negedge with valid&ready is exactly one accepted result.
    always @(negedge clk) begin
        if (rst_n && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got 0x%0h want none", result);
            end else begin
                chk("scoreboard", 16'(result), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b, input logic v);
        sn_bit   = b;
        sn_valid = v;
        tick();
    endtask

    task automatic stop();
        sn_bit   = 1'b0;
        sn_valid = 1'b0;
    endtask

    task automatic begin_win(input logic [3:0] k, input logic bip, input logic cont);
        win_log2   = k;
        bipolar    = bip;
        continuous = cont;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic run_win(input string name, input logic [3:0] k, input logic bip,
                           input int n, input logic [255:0] pat, input logic [15:0] exp);
        exp_q.push_back(exp);
        begin_win(k, bip, 1'b0);
        for (int i = 0; i < n; i++) feed(pat[i], 1'b1);
        stop();
        chk({name, "_busy"}, 16'(busy), 16'd0);
        chk({name, "_valid"}, 16'(result_valid), 16'd1);
        chk({name, "_result"}, 16'(result), exp);
        tick();
    endtask

    logic [255:0] pat8;
    logic [255:0] ones_p;
    logic [11:0]  cbits;

    initial begin
        rst_n = 1'b0; sn_bit = 0; sn_valid = 0; win_log2 = 0; bipolar = 0;
        start = 0; continuous = 0; abort = 0; result_ready = 1'b1;
        pat8   = 256'b01001101;
        ones_p = '1;
        #12;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_result", 16'(result), 16'd0);
        chk("rst_valid", 16'(result_valid), 16'd0);
        chk("rst_overrun", 16'(overrun), 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_win("k3_uni", 4'd3, 1'b0, 8, pat8, 16'd4);
        run_win("k3_bip", 4'd3, 1'b1, 8, pat8, 16'd0);
        run_win("k8_bip_ones", 4'd8, 1'b1, 256, ones_p, 16'h100);
        run_win("k8_uni_ones", 4'd8, 1'b0, 256, ones_p, 16'd256);
        run_win("k8_bip_zeros", 4'd8, 1'b1, 256, '0, 16'h300);
        run_win("k15_clamp", 4'd15, 1'b0, 256, ones_p, 16'd256);

        // k=2 continuous, sn_valid toggling; idle cycles carry sn_bit=1.
        cbits = 12'b1111_0000_1011;
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd4);
        begin_win(4'd2, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            continuous = (i < 8);
            feed(cbits[i], 1'b1);
            feed(1'b1, 1'b0);
        end
        stop();
        chk("cont_overrun", 16'(overrun), 16'd0);
        chk("cont_busy", 16'(busy), 16'd0);

        // k=0 overwrite with no consumer.
        result_ready = 1'b0;
        begin_win(4'd0, 1'b0, 1'b1);
        feed(1'b1, 1'b1);
        chk("k0_first", 16'(result), 16'd1);
        chk("k0_first_ovr", 16'(overrun), 16'd0);
        continuous = 1'b0;
        feed(1'b0, 1'b1);
        stop();
        chk("k0_second", 16'(result), 16'd0);
        chk("k0_overrun", 16'(overrun), 16'd1);
        chk("k0_idle", 16'(busy), 16'd0);
        exp_q.push_back(16'd0);
        result_ready = 1'b1;
        tick();
        chk("k0_accepted", 16'(result_valid), 16'd0);
        begin_win(4'd0, 1'b0, 1'b0);
        chk("start_clr_ovr", 16'(overrun), 16'd0);
        chk("start_busy", 16'(busy), 16'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 16'(busy), 16'd0);

        // Abort on the last-bit edge.
        begin_win(4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) feed(1'b1, 1'b1);
        abort = 1'b1;
        feed(1'b1, 1'b1);
        abort = 1'b0;
        stop();
        chk("abort_last_valid", 16'(result_valid), 16'd0);
        chk("abort_last_busy", 16'(busy), 16'd0);
        tick();
        chk("abort_last_later", 16'(result_valid), 16'd0);

        // Reset mid-window with a pending result.
        result_ready = 1'b0;
        begin_win(4'd0, 1'b0, 1'b0);
        feed(1'b1, 1'b1);
        stop();
        chk("pend_valid", 16'(result_valid), 16'd1);
        begin_win(4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) feed(1'b1, 1'b1);
        chk("mid_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 16'(busy), 16'd0);
        chk("mrst_result", 16'(result), 16'd0);
        chk("mrst_valid", 16'(result_valid), 16'd0);
        chk("mrst_overrun", 16'(overrun), 16'd0);
        stop();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 16'(busy), 16'd0);
        result_ready = 1'b1;

        // Accept and new load on the same edge.
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd1);
        begin_win(4'd0, 1'b0, 1'b1);
        feed(1'b1, 1'b1);
        feed(1'b0, 1'b1);
        chk("same_edge_valid", 16'(result_valid), 16'd1);
        chk("same_edge_result", 16'(result), 16'd0);
        chk("same_edge_ovr", 16'(overrun), 16'd0);
        continuous = 1'b0;
        feed(1'b1, 1'b1);
        stop();
        tick();
        tick();
        chk("same_edge_end", 16'(result_valid), 16'd0);
        chk("same_edge_ovr2", 16'(overrun), 16'd0);

        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
